// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational alu between two requesters.
// Each op takes IDLE (accept) -> EXEC (alu enabled) -> RESP (held until consumed).
module alu_arbiter #(
    parameter int SIZE     = 8,
    parameter int NUM_CMDS = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [3:0]        req0_command,
    input  logic [SIZE-1:0]   req0_a,
    input  logic [SIZE-1:0]   req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [3:0]        req1_command,
    input  logic [SIZE-1:0]   req1_a,
    input  logic [SIZE-1:0]   req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [2*SIZE-1:0] rsp0_result,
    output logic              rsp0_overflow,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [2*SIZE-1:0] rsp1_result,
    output logic              rsp1_overflow,
    output logic              alu_enable,
    output logic [3:0]        alu_command,
    output logic [SIZE-1:0]   alu_a,
    output logic [SIZE-1:0]   alu_b,
    input  logic [2*SIZE-1:0] alu_result,
    input  logic              alu_overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic                r_prio;
    logic                r_owner;
    logic [3:0]          r_cmd;
    logic [SIZE-1:0]     r_a;
    logic [SIZE-1:0]     r_b;
    logic [2*SIZE-1:0]   r_result;
    logic                r_overflow;

    logic                w_grant0;
    logic                w_grant1;
    logic                w_accept;
    logic                w_legal;
    logic                w_rspDone;

    // A lone requester always wins; on contention the favoured one (r_prio) wins.
    assign w_grant0 = req0_valid && (!req1_valid || !r_prio);
    assign w_grant1 = req1_valid && (!req0_valid ||  r_prio);

    // Ready is gated by reset so nothing looks accepted while reset is held.
    assign req0_ready = reset_n && (r_state == IDLE) && w_grant0;
    assign req1_ready = reset_n && (r_state == IDLE) && w_grant1;
    assign w_accept   = req0_ready || req1_ready;

    assign w_legal    = ({1'b0, r_cmd} < 5'(NUM_CMDS));
    assign alu_enable = (r_state == EXEC) && w_legal;

    assign rsp0_valid = (r_state == RESP) && !r_owner;
    assign rsp1_valid = (r_state == RESP) &&  r_owner;
    assign w_rspDone  = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

    assign alu_command   = r_cmd;
    assign alu_a         = r_a;
    assign alu_b         = r_b;
    assign rsp0_result   = r_result;
    assign rsp1_result   = r_result;
    assign rsp0_overflow = r_overflow;
    assign rsp1_overflow = r_overflow;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = EXEC;
            EXEC:    w_nextState = RESP;
            RESP:    if (w_rspDone) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Illegal commands never enable the alu and return an all-zero result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prio     <= 1'b0;
            r_owner    <= 1'b0;
            r_cmd      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (r_state == IDLE && w_accept) begin
                r_owner <= req1_ready;
                r_cmd   <= req1_ready ? req1_command : req0_command;
                r_a     <= req1_ready ? req1_a       : req0_a;
                r_b     <= req1_ready ? req1_b       : req0_b;
            end
            if (r_state == EXEC) begin
                r_result   <= w_legal ? alu_result : '0;
                r_overflow <= w_legal && alu_overflow;
            end
            if (w_rspDone) begin
                r_prio <= ~r_owner;
            end
        end
    end

endmodule
